// File: rtl/regfile_param.sv
// regfile_param: DEPTH x WIDTH register file with one synchronous write port
// and two combinational read ports. The file has an optional hardwired-zero
// register and optional same-cycle write-to-read forwarding. Addresses at or
// above DEPTH are ignored on both the write port and the read ports.
module regfile_param #(
   parameter int WIDTH    = 64,
   parameter int DEPTH    = 32,
   parameter int ZERO_REG = 31,
   parameter int BYPASS   = 1,
   parameter int ADDR_W   = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [WIDTH-1:0]  WriteData,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2
);

   // An address is "live" when it names a real register other than the
   // hardwired zero. The comparison is done at full integer width so that an
   // out-of-range address is never truncated onto a real register.
   function automatic logic addr_live(input logic [ADDR_W-1:0] a);
      return (int'(a) < DEPTH) && (int'(a) != ZERO_REG);
   endfunction

   logic [WIDTH-1:0]  regs [DEPTH];
   logic [DEPTH-1:0]  wr_sel;
   logic [ADDR_W-1:0] rd_addr [2];
   logic [WIDTH-1:0]  rd_data [2];

   assign rd_addr[0] = ReadRegister1;
   assign rd_addr[1] = ReadRegister2;
   assign ReadData1  = rd_data[0];
   assign ReadData2  = rd_data[1];

   // Decode the write port into one enable per register.
   always_comb begin
      // NOTE: every signal written in always_comb gets a default first, so no
      // path through the block can leave it unassigned and infer a latch.
      wr_sel = '0;
      for (int i = 0; i < DEPTH; i++) begin
         wr_sel[i] = RegWrite && addr_live(WriteRegister) && (int'(WriteRegister) == i);
      end
   end

   // Storage: each register either loads WriteData or recirculates its value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the whole array is cleared by the async reset because the
         // file must read all-zero the instant reset asserts. That makes it
         // flops rather than a RAM macro, which is intended for this size.
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // NOTE: state is updated with non-blocking assignments only, so
            // every register samples the pre-edge values of its inputs.
            if (wr_sel[i]) begin
               regs[i] <= WriteData;
            end
         end
      end
   end

   // Read muxes. Dead addresses and reset force 0. Otherwise a matching
   // write in the same cycle is forwarded (when BYPASS is set). Otherwise
   // the stored value is returned.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_data[p] = '0;
         if (reset && addr_live(rd_addr[p])) begin
            if ((BYPASS != 0) && RegWrite && (WriteRegister == rd_addr[p])) begin
               rd_data[p] = WriteData;
            end else begin
               rd_data[p] = regs[rd_addr[p]];
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param. It drives three instances:
//   dut_b : default parameters (64x32, zero reg 31, bypass on)
//   dut_n : same geometry, bypass off (shares dut_b's inputs)
//   dut_s : 16-bit x 20 entries, zero reg 19, bypass on
module tb_regfile_param;

   localparam logic [63:0] K = 64'h0101_0101_0101_0101;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [4:0]  wa;
   logic [63:0] wd;
   logic [4:0]  ra1, ra2;
   logic [63:0] rd1_b, rd2_b, rd1_n, rd2_n;

   logic        s_we;
   logic [4:0]  s_wa;
   logic [15:0] s_wd;
   logic [4:0]  s_ra1, s_ra2;
   logic [15:0] s_rd1, s_rd2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic [4:0]  ra1;
      logic [4:0]  ra2;
      logic [63:0] e1b;   // expected pre-edge ReadData1, bypass on
      logic [63:0] e2b;   // expected pre-edge ReadData2, bypass on
      logic [63:0] e1n;   // expected pre-edge ReadData1, bypass off
      logic [63:0] e2n;   // expected pre-edge ReadData2, bypass off
   } vec_t;

   vec_t vecs [8];

   regfile_param dut_b (
      .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
      .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_b), .ReadData2(rd2_b)
   );

   regfile_param #(.BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .RegWrite(we), .WriteRegister(wa), .WriteData(wd),
      .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1_n), .ReadData2(rd2_n)
   );

   regfile_param #(.WIDTH(16), .DEPTH(20), .ZERO_REG(19), .BYPASS(1)) dut_s (
      .clk(clk), .reset(reset), .RegWrite(s_we), .WriteRegister(s_wa), .WriteData(s_wd),
      .ReadRegister1(s_ra1), .ReadRegister2(s_ra2), .ReadData1(s_rd1), .ReadData2(s_rd2)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] small_exp(input int a);
      case (a)
         9:       return 16'h1234;
         18:      return 16'h00FF;
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      reset = 1'b0;
      we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
      s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;

      // ---------------- reset blocks writes and bypass ----------------
      we = 1'b1; wa = 5'd5; wd = 64'hDEAD; ra1 = 5'd5; ra2 = 5'd5;
      #1;
      check("rst_rd1_b", rd1_b, 64'h0);
      check("rst_rd2_n", rd2_n, 64'h0);
      tick();
      check("rst_edge_rd1_b", rd1_b, 64'h0);
      check("rst_edge_rd1_n", rd1_n, 64'h0);
      reset = 1'b1;
      #1;
      // Deassertion alone does not write: only the forwarded value shows.
      check("rel_fwd_rd1_b", rd1_b, 64'hDEAD);
      check("rel_nowrite_rd1_n", rd1_n, 64'h0);
      tick();
      we = 1'b0;
      #1;
      check("first_write_rd1_b", rd1_b, 64'hDEAD);
      check("first_write_rd2_n", rd2_n, 64'hDEAD);

      // ---------------- full sweep ----------------
      we = 1'b1;
      for (int i = 0; i < 31; i++) begin
         wa = 5'(i);
         wd = 64'(i) * K;
         tick();
      end
      we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         logic [63:0] e1, e2;
         ra1 = 5'(i);
         ra2 = 5'(31 - i);
         e1 = (i == 31) ? 64'h0 : 64'(i) * K;
         e2 = (i == 0) ? 64'h0 : 64'(31 - i) * K;
         #1;
         check($sformatf("sweep_rd1_b[%0d]", i), rd1_b, e1);
         check($sformatf("sweep_rd2_b[%0d]", 31 - i), rd2_b, e2);
         check($sformatf("sweep_rd1_n[%0d]", i), rd1_n, e1);
         check($sformatf("sweep_rd2_n[%0d]", 31 - i), rd2_n, e2);
      end

      // ---------------- table: zero reg, bypass, same-address reads ----------------
      vecs[0] = '{1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31,
                  64'h0, 64'h0, 64'h0, 64'h0};
      vecs[1] = '{1'b0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31,
                  64'h0, 64'h0, 64'h0, 64'h0};
      vecs[2] = '{1'b1, 5'd3, 64'h1, 5'd0, 5'd1,
                  64'h0, K, 64'h0, K};
      vecs[3] = '{1'b1, 5'd3, 64'h2, 5'd3, 5'd4,
                  64'h2, 64'h0404_0404_0404_0404, 64'h1, 64'h0404_0404_0404_0404};
      vecs[4] = '{1'b0, 5'd3, 64'h0, 5'd3, 5'd3,
                  64'h2, 64'h2, 64'h2, 64'h2};
      vecs[5] = '{1'b1, 5'd7, 64'hCAFE, 5'd3, 5'd7,
                  64'h2, 64'hCAFE, 64'h2, 64'h0707_0707_0707_0707};
      vecs[6] = '{1'b1, 5'd7, 64'h1234, 5'd7, 5'd7,
                  64'h1234, 64'h1234, 64'hCAFE, 64'hCAFE};
      vecs[7] = '{1'b0, 5'd7, 64'h0, 5'd7, 5'd30,
                  64'h1234, 64'h1E1E_1E1E_1E1E_1E1E, 64'h1234, 64'h1E1E_1E1E_1E1E_1E1E};

      for (int v = 0; v < 8; v++) begin
         we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
         ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
         #1;
         check($sformatf("vec%0d_rd1_b", v), rd1_b, vecs[v].e1b);
         check($sformatf("vec%0d_rd2_b", v), rd2_b, vecs[v].e2b);
         check($sformatf("vec%0d_rd1_n", v), rd1_n, vecs[v].e1n);
         check($sformatf("vec%0d_rd2_n", v), rd2_n, vecs[v].e2n);
         tick();
      end
      we = 1'b0;

      // ---------------- non-power-of-two instance ----------------
      s_we = 1'b1; s_wa = 5'd9; s_wd = 16'h1234;
      tick();
      s_wa = 5'd18; s_wd = 16'h00FF;
      tick();
      s_wa = 5'd25; s_wd = 16'hABCD; s_ra1 = 5'd25; s_ra2 = 5'd9;
      #1;
      check("small_oob_fwd", 64'(s_rd1), 64'h0);
      check("small_r9_pre", 64'(s_rd2), 64'h1234);
      tick();
      s_we = 1'b0;
      for (int i = 0; i < 20; i++) begin
         s_ra1 = 5'(i);
         s_ra2 = 5'(19 - i);
         #1;
         check($sformatf("small_rd1[%0d]", i), 64'(s_rd1), 64'(small_exp(i)));
         check($sformatf("small_rd2[%0d]", 19 - i), 64'(s_rd2), 64'(small_exp(19 - i)));
      end
      s_ra1 = 5'd25; s_ra2 = 5'd31;
      #1;
      check("small_rd_25", 64'(s_rd1), 64'h0);
      check("small_rd_31", 64'(s_rd2), 64'h0);
      s_we = 1'b1; s_wa = 5'd19; s_wd = 16'hFFFF; s_ra1 = 5'd19; s_ra2 = 5'd18;
      #1;
      check("small_zero_pre", 64'(s_rd1), 64'h0);
      check("small_r18_pre", 64'(s_rd2), 64'h00FF);
      tick();
      s_we = 1'b0;
      #1;
      check("small_zero_post", 64'(s_rd1), 64'h0);

      // ---------------- async reset between edges ----------------
      ra1 = 5'd7; ra2 = 5'd30; s_ra1 = 5'd9;
      @(posedge clk);
      #1;
      check("pre_rst_rd1_b", rd1_b, 64'h1234);
      #2;
      reset = 1'b0;   // 3 ns after the edge, no clock edge until t+5
      #1;
      check("async_rd1_b", rd1_b, 64'h0);
      check("async_rd2_b", rd2_b, 64'h0);
      check("async_rd1_n", rd1_n, 64'h0);
      check("async_rd2_n", rd2_n, 64'h0);
      check("async_small", 64'(s_rd1), 64'h0);
      // A write on an edge while reset is low is lost.
      we = 1'b1; wa = 5'd7; wd = 64'h5555;
      tick();
      we = 1'b0;
      reset = 1'b1;
      #1;
      check("post_rst_rd1_b", rd1_b, 64'h0);
      check("post_rst_rd2_b", rd2_b, 64'h0);
      check("post_rst_rd1_n", rd1_n, 64'h0);
      check("post_rst_small", 64'(s_rd1), 64'h0);
      tick();
      check("post_rst_edge_rd1_b", rd1_b, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised multi-ported register file, the generalised successor to the fixed 64-bit enable register. It holds DEPTH words of WIDTH bits, with one synchronous write port and two combinational read ports. It has a hardwired-zero register, optional write-to-read bypass, and ignores out-of-range addresses. It sits in the CPU datapath between decode and the ALU operand muxes.

Parameters:
WIDTH, 64, data width of each register in bits (>=1)
DEPTH, 32, number of registers (>=2; need not be a power of two)
ZERO_REG, 31, index of the register that always reads 0 and ignores writes; set to DEPTH or above to disable it
BYPASS, 1, 1 = a write in the current cycle is forwarded to a matching read port; 0 = reads show only stored state
ADDR_W, $clog2(DEPTH), address width; derived, not overridden

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all registers immediately
RegWrite  input  1  write enable
WriteRegister  input  ADDR_W  write address
WriteData  input  WIDTH  write data
ReadRegister1  input  ADDR_W  read address, port 1
ReadRegister2  input  ADDR_W  read address, port 2
ReadData1  output  WIDTH  read data, port 1 (combinational)
ReadData2  output  WIDTH  read data, port 2 (combinational)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low: reset=0 forces every stored register to 0 at once, independent of clk.
- While reset=0, writes are blocked. ReadData1/2 = 0 for every address, and bypass is suppressed.
- Reset deassertion (0->1) does not write. The first write takes effect at the first rising clk edge with reset=1.
- Write at rising clk: if reset=1, RegWrite=1, WriteRegister<DEPTH and WriteRegister!=ZERO_REG, then reg[WriteRegister] <= WriteData. Otherwise no register changes.
- Each register holds its value when not written (per-bit enable-mux recirculation into a flop, as in the 64-bit register).
- Read, port n, is purely combinational with zero-cycle latency:
  - ReadRegisterN >= DEPTH -> 0
  - ReadRegisterN == ZERO_REG -> 0
  - else if BYPASS=1, RegWrite=1, WriteRegister==ReadRegisterN and reset=1 -> WriteData (forwarded in the same cycle)
  - else -> reg[ReadRegisterN]
- Both ports may read the same address simultaneously; both return identical data.
- Simultaneous read and write of the same address with BYPASS=0: the read returns the old value during that cycle and the new value after the edge.
- An out-of-range write address is silently dropped. No other register is aliased (no address truncation).
- Reset mid-operation: a reset asserted between edges clears the state immediately. A write whose edge coincides with reset=0 is lost.
- ZERO_REG is never stored; reads return 0 even right after a write to it.
- Widths are exact. There is no sign handling: data is an opaque bit vector.

Test Plan:
- Reset: hold reset=0, pulse clk with RegWrite=1, WriteRegister=5, WriteData=64'hDEAD -> ReadData1 for address 5 = 0; after release and one more edge -> address 5 = 64'hDEAD.
- Full sweep: write reg[i] = i*64'h0101_0101_0101_0101 for i=0..30, then read all on both ports -> values match; address 31 reads 0.
- Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to address 31 -> ReadData1 = ReadData2 = 0 both before and after the edge, with BYPASS=1.
- Bypass: reg[3]=64'h1. Same cycle: RegWrite=1, WriteRegister=3, WriteData=64'h2, ReadRegister1=3 -> ReadData1 = 64'h2 before the edge. Repeat with BYPASS=0 -> 64'h1 before the edge, 64'h2 after.
- Non-power-of-two DEPTH=20, WIDTH=16, ZERO_REG=19: write 16'hABCD to address 25 -> no register changes, and a read of 25 = 0; address 9 is unaffected.
- Async reset mid-cycle: registers loaded; drop reset 3 ns after an edge with no clk edge in between -> all reads return 0 immediately.
